watch_ctrl: RTL and testbench
=============================

// Module: watch_ctrl
// PURPOSE
//  Parametrised stopwatch run-control FSM for the watch datapath. Takes raw
//  START/STOP and LAP/RESET push-buttons, synchronises and debounces them, and
//  drives registered, glitch-free counter enable (CLKEN), counter clear (RST)
//  and display-freeze (LAPHOLD) strobes. Adds lap-hold mode, button-based
//  clear, and auto-stop on DCM lock loss.
// PARAMETERS
//  DB_CYCLES  4   consecutive stable cycles needed before a button level is accepted (>=1)
//  DB_W       16  debounce counter width; 2**DB_W > DB_CYCLES
//  LAP_EN     1   1: LAP/RESET button enters lap-hold while running; 0: ignored while running
// PORTS
//  CLK       in   1  system clock
//  RESET     in   1  asynchronous, active-high reset
//  STRTSTOP  in   1  raw START/STOP button, asynchronous to CLK, active-high
//  LAPRST    in   1  raw LAP/RESET button, asynchronous to CLK, active-high
//  locked    in   1  DCM lock indication, synchronous to CLK
//  CLKEN     out  1  counter enable, registered
//  RST       out  1  counter synchronous clear, registered, one-cycle pulse
//  LAPHOLD   out  1  display latch freeze, registered
//  RUNNING   out  1  status, equals CLKEN
// BEHAVIOUR
//  Reset: state=CLEAR; CLKEN=RST=LAPHOLD=RUNNING=0; sync flops, filtered levels, counters=0.
//  Input path, per button: 2-flop synchroniser -> s2. Debounce counter clears whenever
//   s2==filt. Each cycle s2!=filt, it increments. Once it has counted DB_CYCLES
//   consecutive mismatches: filt<=s2 and counter clears.
//   press pulse = filt & ~filt_q, high exactly 1 cycle on each accepted rising level.
//   No pulse on release. A glitch shorter than DB_CYCLES cycles produces no pulse.
//  Pulse qualification: ss = ss_press & locked; lp = lap_press & locked. Presses while locked=0 are discarded, not queued.
//  FSM, one-hot {CLEAR,ZERO,RUN,LAP,STOPPED}; next state evaluated each cycle, priority top-down:
//   CLEAR  : -> ZERO unconditionally.
//   ZERO   : ss -> RUN; lp ignored.
//   RUN    : ~locked -> STOPPED; ss -> STOPPED; lp & LAP_EN -> LAP.
//   LAP    : ~locked -> STOPPED; ss -> STOPPED; lp -> RUN (display released).
//   STOPPED: ss -> RUN (resume, no clear); lp -> CLEAR.
//   Illegal encoding -> CLEAR.
//  Simultaneous ss and lp in one cycle: ss wins; lp is dropped.
//  Outputs are registered decodes of current_state, so each lags the state by one cycle:
//   CLKEN <= state in {RUN,LAP}; RST <= state==CLEAR; LAPHOLD <= state==LAP; RUNNING = CLKEN.
//  Latency: pulse high in cycle n -> state changes at edge n+1 -> outputs change at edge n+2.
//  After RESET deasserts, RST is high for exactly 1 cycle (the second edge), then ZERO idles with all outputs 0.
//  Lock loss mid-count freezes the count (STOPPED) and does not clear it. A clear needs an explicit LAP/RESET press in STOPPED.
//  RESET mid-operation: immediate return to reset values, then the normal CLEAR sequence.
//  Button held indefinitely: one pulse only. The button must be released and re-pressed to generate another.
// TESTING
//  1 Reset release, no buttons -> RST=1 for exactly 1 cycle at edge 2; CLKEN/LAPHOLD stay 0.
//  2 DB_CYCLES=4, locked=1, hold STRTSTOP 10 cycles -> one pulse ~6 cycles after rise;
//    CLKEN=1 2 cycles later; 3-cycle glitch -> no pulse, CLKEN unchanged.
//  3 Sequence START, LAP, LAP, STOP, START -> CLKEN 1,1,1,0,1; LAPHOLD 0,1,0,0,0;
//    no RST pulse anywhere in the sequence.
//  4 STOPPED, press LAPRST -> RST=1 one cycle, then ZERO; next START restarts counting.
//  5 RUN, drop locked for 1 cycle -> CLKEN=0 2 cycles later, state STOPPED.
//    START press while locked=0 -> ignored.
//  6 STRTSTOP and LAPRST pulses in the same cycle in RUN -> STOPPED, LAPHOLD stays 0.
//    LAP_EN=0: LAPRST in RUN -> no change.

Source files
------------

// File: rtl/watch_ctrl.sv
// Stopwatch run-control: synchronised, debounced START/STOP and LAP/RESET buttons
// drive a one-hot FSM whose registered decodes give CLKEN, RST and LAPHOLD.

module watch_ctrl_db #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic            s1_q, s2_q;
  logic            filt_q, filt_d;
  logic            filt_dly_q;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Debounce: accept s2 once it has disagreed with filt for DB_CYCLES cycles in a row.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = {DB_W{1'b0}};
    if (s2_q == filt_q) begin
      cnt_d = {DB_W{1'b0}};
    end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
      filt_d = s2_q;
      cnt_d  = {DB_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(DB_W-1){1'b0}}, 1'b1};
    end
  end

  // Synchroniser, filtered level and its delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= {DB_W{1'b0}};
    end else begin
      s1_q       <= btn;
      s2_q       <= s1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
    end
  end

  assign press = filt_q & ~filt_dly_q;

endmodule

module watch_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 16,
  parameter int LAP_EN    = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic STRTSTOP,
  input  logic LAPRST,
  input  logic locked,
  output logic CLKEN,
  output logic RST,
  output logic LAPHOLD,
  output logic RUNNING
);

  typedef enum logic [4:0] {
    CLEAR   = 5'b00001,
    ZERO    = 5'b00010,
    RUN     = 5'b00100,
    LAP     = 5'b01000,
    STOPPED = 5'b10000
  } state_e;

  state_e state_q, state_d;
  logic   ss_press_s, lap_press_s;
  logic   ss_s, lp_s;
  logic   clken_q, clken_d;
  logic   rst_q, rst_d;
  logic   lap_q, lap_d;

  watch_ctrl_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_ss (
    .clk   (CLK),
    .rst   (RESET),
    .btn   (STRTSTOP),
    .press (ss_press_s)
  );

  watch_ctrl_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_lp (
    .clk   (CLK),
    .rst   (RESET),
    .btn   (LAPRST),
    .press (lap_press_s)
  );

  // Presses arriving while the DCM is unlocked are dropped, not queued.
  assign ss_s = ss_press_s & locked;
  assign lp_s = lap_press_s & locked;

  // Next state; START/STOP is tested before LAP/RESET so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: state_d = ZERO;
      ZERO: begin
        if (ss_s) state_d = RUN;
        else      state_d = state_q;
      end
      RUN: begin
        if (!locked)                     state_d = STOPPED;
        else if (ss_s)                   state_d = STOPPED;
        else if (lp_s && (LAP_EN != 0))  state_d = LAP;
        else                             state_d = state_q;
      end
      LAP: begin
        if (!locked)   state_d = STOPPED;
        else if (ss_s) state_d = STOPPED;
        else if (lp_s) state_d = RUN;
        else           state_d = state_q;
      end
      STOPPED: begin
        if (ss_s)      state_d = RUN;
        else if (lp_s) state_d = CLEAR;
        else           state_d = state_q;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Output strobes decode the current state so they lag it by one cycle.
  always_comb begin
    clken_d = (state_q == RUN) || (state_q == LAP);
    rst_d   = (state_q == CLEAR);
    lap_d   = (state_q == LAP);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= CLEAR;
      clken_q <= 1'b0;
      rst_q   <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clken_q <= clken_d;
      rst_q   <= rst_d;
      lap_q   <= lap_d;
    end
  end

  assign CLKEN   = clken_q;
  assign RST     = rst_q;
  assign LAPHOLD = lap_q;
  assign RUNNING = clken_q;

endmodule

// File: tb/tb_watch_ctrl.sv
// Randomised button/lock stimulus on two watch_ctrl configurations, checked
// cycle by cycle against a behavioural model of the stopwatch rules.

module tb_watch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic strt = 1'b0;
  logic lapb = 1'b0;
  logic locked = 1'b1;
  logic clken0, rstp0, hold0, run0;
  logic clken1, rstp1, hold1, run1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  watch_ctrl #(.DB_CYCLES(4), .DB_W(16), .LAP_EN(1)) dut0 (
    .CLK(clk), .RESET(rst), .STRTSTOP(strt), .LAPRST(lapb), .locked(locked),
    .CLKEN(clken0), .RST(rstp0), .LAPHOLD(hold0), .RUNNING(run0)
  );

  watch_ctrl #(.DB_CYCLES(3), .DB_W(4), .LAP_EN(0)) dut1 (
    .CLK(clk), .RESET(rst), .STRTSTOP(strt), .LAPRST(lapb), .locked(locked),
    .CLKEN(clken1), .RST(rstp1), .LAPHOLD(hold1), .RUNNING(run1)
  );

  localparam int M_CLEAR = 0;
  localparam int M_ZERO  = 1;
  localparam int M_RUN   = 2;
  localparam int M_LAP   = 3;
  localparam int M_STOP  = 4;

  int m_db[2]    = '{4, 3};
  bit m_lapen[2] = '{1'b1, 1'b0};
  bit m_s1[2][2];
  bit m_s2[2][2];
  bit m_filt[2][2];
  bit m_fprev[2][2];
  int m_run[2][2];
  int m_st[2];
  bit e_clken[2];
  bit e_rst[2];
  bit e_hold[2];

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0b want=%0b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge, using the inputs present before the edge.
  task automatic model_step();
    bit raw[2];
    bit pr[2];
    bit ss, lp;
    raw[0] = strt;
    raw[1] = lapb;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int b = 0; b < 2; b++) begin
          m_s1[i][b] = 1'b0; m_s2[i][b] = 1'b0;
          m_filt[i][b] = 1'b0; m_fprev[i][b] = 1'b0; m_run[i][b] = 0;
        end
        m_st[i] = M_CLEAR;
        e_clken[i] = 1'b0; e_rst[i] = 1'b0; e_hold[i] = 1'b0;
      end else begin
        for (int b = 0; b < 2; b++) begin
          pr[b] = m_filt[i][b] && !m_fprev[i][b];
          m_fprev[i][b] = m_filt[i][b];
          if (m_s2[i][b] != m_filt[i][b]) begin
            m_run[i][b]++;
            if (m_run[i][b] == m_db[i]) begin
              m_filt[i][b] = m_s2[i][b];
              m_run[i][b] = 0;
            end
          end else begin
            m_run[i][b] = 0;
          end
          m_s2[i][b] = m_s1[i][b];
          m_s1[i][b] = raw[b];
        end
        ss = pr[0] && locked;
        lp = pr[1] && locked;
        e_clken[i] = (m_st[i] == M_RUN) || (m_st[i] == M_LAP);
        e_rst[i]   = (m_st[i] == M_CLEAR);
        e_hold[i]  = (m_st[i] == M_LAP);
        case (m_st[i])
          M_CLEAR: m_st[i] = M_ZERO;
          M_ZERO:  if (ss) m_st[i] = M_RUN;
          M_RUN: begin
            if (!locked || ss)          m_st[i] = M_STOP;
            else if (lp && m_lapen[i])  m_st[i] = M_LAP;
          end
          M_LAP: begin
            if (!locked || ss) m_st[i] = M_STOP;
            else if (lp)       m_st[i] = M_RUN;
          end
          M_STOP: begin
            if (ss)      m_st[i] = M_RUN;
            else if (lp) m_st[i] = M_CLEAR;
          end
          default: m_st[i] = M_CLEAR;
        endcase
      end
    end
  endtask

  initial begin
    int ss_left = 0;
    int lp_left = 0;
    int lock_cnt = 0;
    for (cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 3) || (cyc >= 3000 && cyc < 3002);
      if (ss_left == 0) begin
        strt = ~strt;
        ss_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 14);
        if ($urandom_range(0, 3) == 0) begin
          lapb = strt;
          lp_left = ss_left;
        end
      end
      ss_left--;
      if (lp_left == 0) begin
        lapb = ~lapb;
        lp_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 20);
      end
      lp_left--;
      if (lock_cnt == 0 && $urandom_range(0, 59) == 0) lock_cnt = $urandom_range(1, 3);
      locked = (lock_cnt == 0);
      if (lock_cnt > 0) lock_cnt--;
      @(posedge clk);
      model_step();
      #1;
      check("clken0",   clken0, e_clken[0]);
      check("rst0",     rstp0,  e_rst[0]);
      check("laphold0", hold0,  e_hold[0]);
      check("running0", run0,   e_clken[0]);
      check("clken1",   clken1, e_clken[1]);
      check("rst1",     rstp1,  e_rst[1]);
      check("laphold1", hold1,  e_hold[1]);
      check("running1", run1,   e_clken[1]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
